// File: rtl/apb_pkg.sv
// Shared definitions for the CPU-to-APB bridge: FSM state encoding, default
// error read data, default peripheral window and the slot-field bounds that
// pick the target slave out of the core address.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } apb_state_e;

    localparam logic [31:0] APB_ERR_DATA    = 32'hDEAD_BEEF;
    localparam logic [15:0] APB_PERIPH_BASE = 16'h4000;

    // rv_addr[SLOT_HI:SLOT_LO] selects the slave inside the window
    localparam int SLOT_HI = 15;
    localparam int SLOT_LO = 8;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog. Counts cycles while en is high (the first enabled
// cycle is count 1) and clears whenever en drops.
//   clk, rst : clock, synchronous active-high reset
//   en       : high while the bridge sits in ACCESS
//   expired  : high in the enabled cycle whose count equals TIMEOUT_CYCLES
module apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // cnt holds the number of enabled cycles already completed, so the
    // current cycle's count is cnt+1.
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) cnt <= '0;
        else            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_bridge_mux.sv
// CPU-to-APB bridge with NUM_SLAVES decoder, PRDATA/PREADY mux, ACCESS
// timeout and sticky error capture.
//   clk, rst                     : clock, synchronous active-high reset
//   rv_addr/rv_wdata             : core address / store data
//   rv_mem_write/rv_mem_read     : core store / load request
//   rv_rdata                     : registered load result
//   cpu_stall                    : combinational stall back to the core
//   err_clr/err_irq/err_addr     : sticky error clear / flag / first address
//   PSEL..PWDATA                 : APB master outputs
//   PRDATA/PREADY/PSLVERR        : per-slave APB returns (flattened PRDATA)
module apb_bridge_mux
    import apb_pkg::*;
#(
    parameter int                 NUM_SLAVES     = 4,
    parameter int                 DATA_W         = 32,
    parameter logic [15:0]        PERIPH_BASE    = APB_PERIPH_BASE,
    parameter int                 TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0]  ERR_DATA       = DATA_W'(APB_ERR_DATA)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  rv_addr,
    input  logic [DATA_W-1:0]            rv_wdata,
    input  logic                         rv_mem_write,
    input  logic                         rv_mem_read,
    output logic [DATA_W-1:0]            rv_rdata,
    output logic                         cpu_stall,
    input  logic                         err_clr,
    output logic                         err_irq,
    output logic [31:0]                  err_addr,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [31:0]                  PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int SLOT_W = SLOT_HI - SLOT_LO + 1;

    apb_state_e state, state_nxt;

    logic [SLOT_W-1:0] slot;
    logic              hit, mapped;
    logic [IDX_W-1:0]  idx_q;
    logic              rdy_sel, slverr_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic              expired;
    logic              xfer_ok, timeout, dec_err, err_set;

    assign slot   = rv_addr[SLOT_HI:SLOT_LO];
    assign hit    = (rv_addr[31:16] == PERIPH_BASE) && (rv_mem_write || rv_mem_read);
    assign mapped = ({{(32-SLOT_W){1'b0}}, slot} < 32'(NUM_SLAVES));

    // Return path from the slave latched at SETUP
    assign rdy_sel    = PREADY[idx_q];
    assign slverr_sel = PSLVERR[idx_q];
    assign rdata_sel  = PRDATA[int'(idx_q)*DATA_W +: DATA_W];

    // PREADY in the expiry cycle wins over the timeout
    assign xfer_ok = (state == ST_ACCESS) && rdy_sel;
    assign timeout = (state == ST_ACCESS) && !rdy_sel && expired;
    assign dec_err = (state == ST_IDLE) && hit && !mapped;
    assign err_set = dec_err || (xfer_ok && slverr_sel) || timeout;

    assign cpu_stall = !rst && hit && (state != ST_DONE);
    assign PENABLE   = (state == ST_ACCESS);

    always_comb begin
        PSEL = '0;
        if (state == ST_SETUP || state == ST_ACCESS) PSEL[idx_q] = 1'b1;
    end

    apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (hit) state_nxt = mapped ? ST_SETUP : ST_DONE;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (rdy_sel || expired) state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request latch and load-result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            PADDR    <= '0;
            PWDATA   <= '0;
            PWRITE   <= 1'b0;
            idx_q    <= '0;
            rv_rdata <= '0;
        end else begin
            if (state == ST_IDLE && hit && mapped) begin
                PADDR  <= rv_addr;
                PWDATA <= rv_wdata;
                PWRITE <= rv_mem_write;
                idx_q  <= slot[IDX_W-1:0];
            end
            if (dec_err && !rv_mem_write)
                rv_rdata <= ERR_DATA;
            else if (xfer_ok && !PWRITE)
                rv_rdata <= slverr_sel ? ERR_DATA : rdata_sel;
            else if (timeout && !PWRITE)
                rv_rdata <= ERR_DATA;
        end
    end

    // Sticky error: first error address is kept until acknowledged; a set
    // coinciding with a clear counts as a fresh first error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_irq  <= 1'b0;
            err_addr <= '0;
        end else if (err_set) begin
            err_irq <= 1'b1;
            if (!err_irq || err_clr) err_addr <= rv_addr;
        end else if (err_clr) begin
            err_irq <= 1'b0;
        end
    end

endmodule

// File: doc/apb_bridge_mux.md
# apb_bridge_mux

Parametrised CPU-to-APB bridge with an integrated N-slave decoder, read-data mux, access timeout and error capture. Sits between the RISC-V core's data port and the peripheral bus at the top level: detects accesses to the peripheral window, runs an APB SETUP/ACCESS transfer to one of `NUM_SLAVES` slaves, and stalls the core until completion. Replaces the single-slave bridge plus hand-wired select/PRDATA logic. Adds three behaviours that path did not have:
- per-slave PRDATA/PREADY muxing;
- a bus-hang timeout;
- decode, slave and timeout error reporting.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of APB slaves, 1..16.
- `DATA_W`, 32: data width.
- `PERIPH_BASE`, 16'h4000: value of `rv_addr[31:16]` that selects the peripheral window.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles before abort, ≥2.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on any error.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rv_addr` in 32: core data address; held stable while `cpu_stall`=1.
- `rv_wdata` in DATA_W: core store data.
- `rv_mem_write` in 1: store request.
- `rv_mem_read` in 1: load request.
- `rv_rdata` out DATA_W: registered load result.
- `cpu_stall` out 1: combinational stall to the core.
- `err_clr` in 1: clears the sticky error status.
- `err_irq` out 1: sticky error flag.
- `err_addr` out 32: address of the first unacknowledged error.
- `PSEL` out NUM_SLAVES: one-hot slave select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB write.
- `PADDR` out 32: APB address.
- `PWDATA` out DATA_W: APB write data.
- `PRDATA` in NUM_SLAVES*DATA_W: flattened; slave i occupies bits [i*DATA_W +: DATA_W].
- `PREADY` in NUM_SLAVES: per-slave ready.
- `PSLVERR` in NUM_SLAVES: per-slave error.

## Operation
- Request: `hit = (rv_addr[31:16]==PERIPH_BASE) & (rv_mem_write | rv_mem_read)`. Writes take priority if both requests are high.
- Slave index: `idx = rv_addr[15:8]`.
- Mapped: `idx < NUM_SLAVES`; otherwise the access is unmapped.
- FSM states are IDLE, SETUP, ACCESS and DONE.
  - IDLE: on `hit` and mapped, latch address, data and direction into PADDR/PWDATA/PWRITE and go to SETUP. On `hit` and unmapped, go straight to DONE with a decode error.
  - SETUP: `PSEL[idx]`=1, PENABLE=0. Unconditionally go to ACCESS.
  - ACCESS: PSEL held, PENABLE=1.
    - On `PREADY[idx]`: capture `PRDATA[idx]` (reads) and `PSLVERR[idx]`, then go to DONE.
    - If the watchdog reaches TIMEOUT_CYCLES first: abort with a timeout error and go to DONE.
  - DONE: PSEL and PENABLE = 0, and `cpu_stall`=0 for exactly this cycle. Always return to IDLE.
- `cpu_stall = hit & (state != DONE)`, forced 0 while `rst`.
- `rv_rdata` write rules:
  - Updated only on read completion.
  - On any error (decode, PSLVERR, timeout), `rv_rdata` = ERR_DATA.
  - On a write, `rv_rdata` is unchanged.
  - Writes that error are dropped; the slave has already seen them except on decode error.
- Error capture:
  - Set: on any error, set `err_irq`. If `err_irq` was 0, also latch `err_addr` = request address. The first error wins; later errors do not overwrite.
  - Clear: `err_clr` clears `err_irq`. `err_addr` retains its value.
  - Simultaneous set and clear: set wins, and `err_addr` is reloaded.
- Watchdog: counts ACCESS cycles from 1, and is cleared outside ACCESS.
- Timeout: fires on the cycle the count equals TIMEOUT_CYCLES with `PREADY[idx]`=0. PREADY in that same cycle counts as success.
- Reset: all outputs and state are cleared; reset mid-transfer drops PSEL/PENABLE the next edge with no completion and no error.

## Timing
Reset values:
- 0: `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `rv_rdata`, `err_irq`, `err_addr`.
- State: IDLE.

Zero-wait mapped access:
- T0: IDLE, stall=1.
- T1: SETUP.
- T2: ACCESS, PREADY sampled.
- T3: DONE, stall=0, `rv_rdata` valid.

Latency:
- Mapped access: 3 stall cycles plus one per wait state.
- Unmapped access: 1 stall cycle.
- Timeout: 2 + TIMEOUT_CYCLES stall cycles.

Handshake:
- PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle.
- Back-to-back peripheral accesses always return through IDLE: SETUP of the second transfer occurs ≥2 cycles after the first DONE.
- Non-peripheral addresses never stall and never drive PSEL.

## Structure
- Shared package `apb_pkg` holds the FSM state enum, the default `ERR_DATA`, the default `PERIPH_BASE` and the slot-field bounds [15:8].
- One sub-module, `apb_watchdog`:
  - Parameter: TIMEOUT_CYCLES.
  - Inputs: `clk`, `rst`, `en`.
  - Output: `expired`.
- Decode and PRDATA mux stay inline as indexed part-selects.

## Test plan
- Read 0x4000_0104, slave 1 PRDATA=0x1234_5678, PREADY=1 → PSEL=4'b0010 for 2 cycles, stall 3 cycles, `rv_rdata`=0x1234_5678.
- Write 0xCAFE_0001 to 0x4000_0008 with slave 0 inserting 2 wait states → PWDATA held 4 cycles, 5 stall cycles, PWRITE=1 throughout.
- Read 0x4000_0700 with NUM_SLAVES=4 → no PSEL, 1 stall cycle, `rv_rdata`=0xDEAD_BEEF, `err_irq`=1, `err_addr`=0x4000_0700.
- Slave 2 PREADY stuck at 0, TIMEOUT_CYCLES=16 → abort after 16 ACCESS cycles, 18 stall cycles, `rv_rdata`=0xDEAD_BEEF, `err_irq`=1.
- PSLVERR=1 on slave 3 in the same cycle `err_clr`=1 while `err_irq` is already set → `err_irq` stays 1, `err_addr` reloaded.
- Assert `rst` during ACCESS → PSEL/PENABLE 0 next edge, `err_irq`=0, the next access completes normally.
